// File: rtl/sh7034_sci_uart_peer.sv
`default_nettype none
// ============================================================================
// Module      : sh7034_sci_uart_peer
// Description : Board-side async serial peer for the SH7034 SCI pins, with
//               16x-oversampled RX/TX engines and small host-side FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module sh7034_sci_uart_peer #(
    parameter int FIFO_AW = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [15:0] BAUD_DIV,
    input  logic        PE,
    input  logic        OE,
    input  logic        STOP,
    input  logic        RXD,
    output logic        TXD,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_WR,
    output logic        TX_FULL,
    output logic        TX_IDLE,
    output logic [7:0]  RX_DATA,
    output logic        RX_PERR,
    output logic        RX_FERR,
    output logic        RX_EMPTY,
    input  logic        RX_RD,
    output logic        RX_OVR
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PAR, TXS_STOP1, TXS_STOP2} tx_state_t;
    typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_PAR, RXS_STOP, RXS_BREAK} rx_state_t;

    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tick;

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        tick       = 1'b0;
        if (CE) begin
            if (baud_cnt_q >= BAUD_DIV) begin
                tick       = 1'b1;
                baud_cnt_d = '0;
            end else begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end
        end
    end

    // TX FIFO and frame engine
    logic [7:0]       tx_mem_q [DEPTH];
    logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic             tx_empty, tx_full, tx_push, tx_pop, tx_load;
    logic [7:0]       tx_head;
    tx_state_t        tx_state_q, tx_state_d;
    logic [3:0]       tx_sub_q, tx_sub_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_par_q, tx_par_d, tx_pe_q, tx_pe_d, tx_two_q, tx_two_d, txd_q, txd_d;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                      (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
    assign tx_push  = CE && TX_WR && !tx_full;
    assign tx_head  = tx_mem_q[tx_rd_q[FIFO_AW-1:0]];
    assign tx_wr_d  = tx_wr_q + {{FIFO_AW{1'b0}}, tx_push};
    assign tx_rd_d  = tx_rd_q + {{FIFO_AW{1'b0}}, tx_pop};

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sub_d   = tx_sub_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pe_d    = tx_pe_q;
        tx_two_d   = tx_two_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_sub_d = tx_sub_q + 4'd1;
            case (tx_state_q)
                TXS_IDLE: begin
                    tx_sub_d = '0;
                    tx_load  = !tx_empty;
                end
                TXS_START: if (tx_sub_q == 4'd15) begin
                    tx_state_d = TXS_DATA;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
                TXS_DATA: if (tx_sub_q == 4'd15) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = tx_pe_q ? TXS_PAR : TXS_STOP1;
                        txd_d      = tx_pe_q ? tx_par_q : 1'b1;
                    end else begin
                        txd_d = tx_shift_q[1];
                    end
                end
                TXS_PAR: if (tx_sub_q == 4'd15) begin
                    tx_state_d = TXS_STOP1;
                    txd_d      = 1'b1;
                end
                TXS_STOP1: if (tx_sub_q == 4'd15) begin
                    if (tx_two_q) begin
                        tx_state_d = TXS_STOP2;
                    end else begin
                        tx_state_d = TXS_IDLE;
                        tx_load    = !tx_empty;
                    end
                end
                TXS_STOP2: if (tx_sub_q == 4'd15) begin
                    tx_state_d = TXS_IDLE;
                    tx_load    = !tx_empty;
                end
                default: tx_state_d = TXS_IDLE;
            endcase
            // Loading straight out of a stop bit keeps back-to-back frames gapless
            if (tx_load) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = (^tx_head) ^ OE;
                tx_pe_d    = PE;
                tx_two_d   = STOP;
                tx_state_d = TXS_START;
                tx_sub_d   = '0;
                txd_d      = 1'b0;
            end
        end
    end

    // RX synchroniser: [0]/[1] metastability stages, [2] previous value for edge detect
    logic [2:0]       rx_sync_q, rx_sync_d;
    logic             rx_line, rx_fall;
    logic [9:0]       rx_mem_q [DEPTH];
    logic [FIFO_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic             rx_empty, rx_full, rx_push, rx_pop, rx_ferr, rx_perr;
    logic [9:0]       rx_head;
    rx_state_t        rx_state_q, rx_state_d;
    logic [3:0]       rx_sub_q, rx_sub_d;
    logic [2:0]       rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_pe_q, rx_pe_d, rx_oe_q, rx_oe_d, rx_pbit_q, rx_pbit_d, rx_ovr_q, rx_ovr_d;

    assign rx_sync_d = CE ? {rx_sync_q[1:0], RXD} : rx_sync_q;
    assign rx_line   = rx_sync_q[1];
    assign rx_fall   = rx_sync_q[2] && !rx_sync_q[1];
    assign rx_empty  = (rx_wr_q == rx_rd_q);
    assign rx_full   = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                       (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
    assign rx_pop    = CE && RX_RD && !rx_empty;
    assign rx_head   = rx_mem_q[rx_rd_q[FIFO_AW-1:0]];
    assign rx_wr_d   = rx_wr_q + {{FIFO_AW{1'b0}}, rx_push};
    assign rx_rd_d   = rx_rd_q + {{FIFO_AW{1'b0}}, rx_pop};
    assign rx_ferr   = !rx_line;
    assign rx_perr   = rx_pe_q && (rx_pbit_q != ((^rx_shift_q) ^ rx_oe_q));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sub_d   = rx_sub_q;
        rx_cnt_d   = rx_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_pe_d    = rx_pe_q;
        rx_oe_d    = rx_oe_q;
        rx_pbit_d  = rx_pbit_q;
        rx_ovr_d   = CE ? 1'b0 : rx_ovr_q;
        rx_push    = 1'b0;
        if (tick) begin
            rx_sub_d = rx_sub_q + 4'd1;
        end
        case (rx_state_q)
            RXS_IDLE: if (CE && rx_fall) begin
                rx_state_d = RXS_START;
                rx_sub_d   = '0;
                rx_pe_d    = PE;
                rx_oe_d    = OE;
            end
            RXS_START: if (tick && rx_sub_q == 4'd7) begin
                rx_state_d = rx_line ? RXS_IDLE : RXS_DATA;
                rx_sub_d   = '0;
                rx_cnt_d   = '0;
            end
            RXS_DATA: if (tick && rx_sub_q == 4'd15) begin
                rx_shift_d = {rx_line, rx_shift_q[7:1]};
                rx_cnt_d   = rx_cnt_q + 3'd1;
                if (rx_cnt_q == 3'd7) begin
                    rx_state_d = rx_pe_q ? RXS_PAR : RXS_STOP;
                end
            end
            RXS_PAR: if (tick && rx_sub_q == 4'd15) begin
                rx_pbit_d  = rx_line;
                rx_state_d = RXS_STOP;
            end
            RXS_STOP: if (tick && rx_sub_q == 4'd15) begin
                rx_ovr_d   = rx_full;
                rx_push    = !rx_full;
                rx_state_d = rx_ferr ? RXS_BREAK : RXS_IDLE;
            end
            // A held-low line after a framing error must not look like a new start
            RXS_BREAK: if (CE && rx_line) rx_state_d = RXS_IDLE;
            default: rx_state_d = RXS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wr_q[FIFO_AW-1:0]] <= TX_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            baud_cnt_q <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_state_q <= TXS_IDLE;
            tx_sub_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pe_q    <= 1'b0;
            tx_two_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_sync_q  <= 3'b111;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_state_q <= RXS_IDLE;
            rx_sub_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_pe_q    <= 1'b0;
            rx_oe_q    <= 1'b0;
            rx_pbit_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rx_mem_q[i] <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_state_q <= tx_state_d;
            tx_sub_q   <= tx_sub_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_pe_q    <= tx_pe_d;
            tx_two_q   <= tx_two_d;
            txd_q      <= txd_d;
            rx_sync_q  <= rx_sync_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_state_q <= rx_state_d;
            rx_sub_q   <= rx_sub_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_pe_q    <= rx_pe_d;
            rx_oe_q    <= rx_oe_d;
            rx_pbit_q  <= rx_pbit_d;
            rx_ovr_q   <= rx_ovr_d;
            if (rx_push) rx_mem_q[rx_wr_q[FIFO_AW-1:0]] <= {rx_perr, rx_ferr, rx_shift_q};
        end
    end

    assign TXD      = txd_q;
    assign TX_FULL  = tx_full;
    assign TX_IDLE  = tx_empty && (tx_state_q == TXS_IDLE);
    assign RX_DATA  = rx_head[7:0];
    assign RX_FERR  = rx_head[8];
    assign RX_PERR  = rx_head[9];
    assign RX_EMPTY = rx_empty;
    assign RX_OVR   = rx_ovr_q;
endmodule
`default_nettype wire

// File: tb/tb_sh7034_sci_uart_peer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sh7034_sci_uart_peer
// Description : Randomized self-checking bench for the SCI UART peer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sh7034_sci_uart_peer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, ce, pe, oe, stop, rxd_drv, lb, dut_rxd, txd;
    logic [15:0] baud_div;
    logic [7:0]  tx_data, rx_data;
    logic        tx_wr, tx_full, tx_idle, rx_perr, rx_ferr, rx_empty, rx_rd, rx_ovr;

    assign dut_rxd = lb ? txd : rxd_drv;

    sh7034_sci_uart_peer #(.FIFO_AW(2)) u_dut (
        .CLK(clk), .RST(rst), .CE(ce), .BAUD_DIV(baud_div), .PE(pe), .OE(oe), .STOP(stop),
        .RXD(dut_rxd), .TXD(txd), .TX_DATA(tx_data), .TX_WR(tx_wr), .TX_FULL(tx_full),
        .TX_IDLE(tx_idle), .RX_DATA(rx_data), .RX_PERR(rx_perr), .RX_FERR(rx_ferr),
        .RX_EMPTY(rx_empty), .RX_RD(rx_rd), .RX_OVR(rx_ovr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int L = 16;
    bit ce_rand = 1'b0;
    bit exp_q[$];
    logic [9:0] mq[$];
    int m_ovr = 0;
    int ovr_cnt = 0;
    logic ovr_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        ce = 1'b1;
        forever begin
            @(negedge clk);
            ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rx_ovr && !ovr_prev) ovr_cnt++;
        ovr_prev = rx_ovr;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serial line as a list of bit values, one entry per bit period
    task automatic append_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (pe) exp_q.push_back((^b) ^ oe);
        exp_q.push_back(1'b1);
        if (stop) exp_q.push_back(1'b1);
    endtask

    task automatic mpush(input logic [7:0] b, input bit perr, input bit ferr);
        if (mq.size() < DEPTH) mq.push_back({perr, ferr, b});
        else m_ovr++;
    endtask

    task automatic drain();
        logic [9:0] e;
        while (mq.size() > 0) begin
            e = mq.pop_front();
            chk("rx_not_empty", 32'(rx_empty), 32'd0);
            chk("rx_data", 32'(rx_data), 32'(e[7:0]));
            chk("rx_ferr", 32'(rx_ferr), 32'(e[8]));
            chk("rx_perr", 32'(rx_perr), 32'(e[9]));
            rx_rd = 1'b1;
            @(negedge clk);
            rx_rd = 1'b0;
        end
        chk("rx_empty_after_drain", 32'(rx_empty), 32'd1);
    endtask

    task automatic rx_bit(input logic v);
        rxd_drv = v;
        repeat (L) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit p_en, input bit pbit, input bit sbit, input int brk);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (p_en) rx_bit(pbit);
        rx_bit(sbit);
        if (brk > 0) begin
            rxd_drv = 1'b0;
            repeat (brk) @(negedge clk);
        end
        rx_bit(1'b1);
    endtask

    task automatic tx_stream(input bit fixed, input int k);
        logic [7:0] b0;
        logic [7:0] pb[5];
        int nacc, t, nbits, total, nbad;
        bit e;
        logic cap_txd[$];
        logic cap_idle[$];
        lb = 1'b0;
        if (fixed) begin
            baud_div = 16'd0; pe = 1'b0; oe = 1'b0; stop = 1'b0; b0 = 8'h55;
        end else begin
            baud_div = 16'($urandom_range(0, 1));
            pe = 1'($urandom_range(0, 1));
            oe = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
            b0 = 8'($urandom);
        end
        L = 16 * (int'(baud_div) + 1);
        for (int j = 0; j < 5; j++) pb[j] = 8'($urandom);
        nacc = (k < DEPTH) ? k : DEPTH;
        exp_q.delete();
        append_frame(b0);
        for (int j = 0; j < nacc; j++) append_frame(pb[j]);
        nbits = exp_q.size();
        total = nbits * L + L;
        tx_data = b0;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        t = 0;
        while (txd !== 1'b0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk("tx_start_timeout", 32'(t >= 64), 32'd0);
        if (t >= 64) return;
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    cap_txd.push_back(txd);
                    cap_idle.push_back(tx_idle);
                    @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < k; j++) begin
                    tx_data = pb[j];
                    tx_wr = 1'b1;
                    @(negedge clk);
                end
                tx_wr = 1'b0;
                chk("tx_full", 32'(tx_full), 32'(k >= DEPTH));
            end
        join
        nbad = 0;
        for (int i = 0; i < total; i++) begin
            e = (i < nbits * L) ? exp_q[i / L] : 1'b1;
            if (cap_txd[i] !== e) nbad++;
        end
        chk("tx_wave_bad_samples", 32'(nbad), 32'd0);
        for (int i = 0; i < nbits; i++) chk("tx_bit_centre", 32'(cap_txd[i * L + L / 2]), 32'(exp_q[i]));
        chk("tx_idle_busy", 32'(cap_idle[nbits * L - 1]), 32'd0);
        chk("tx_idle_done", 32'(cap_idle[nbits * L]), 32'd1);
    endtask

    task automatic loopback(input bit fixed, input int n);
        logic [7:0] b[4];
        int t, base;
        if (fixed) begin
            b[0] = 8'hA3; b[1] = 8'h00; b[2] = 8'hFF; b[3] = 8'h00;
        end else begin
            for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
        end
        ce_rand = 1'b0;
        baud_div = 16'($urandom_range(0, 2));
        pe = 1'b1; oe = 1'b1;
        stop = 1'($urandom_range(0, 1));
        L = 16 * (int'(baud_div) + 1);
        @(negedge clk);
        lb = 1'b1;
        base = ovr_cnt;
        @(negedge clk);
        for (int j = 0; j < n; j++) begin
            tx_data = b[j];
            tx_wr = 1'b1;
            mpush(b[j], 1'b0, 1'b0);
            @(negedge clk);
        end
        tx_wr = 1'b0;
        ce_rand = 1'b1;
        t = 0;
        while (tx_idle !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("lb_tx_timeout", 32'(t >= 20000), 32'd0);
        cycles(2 * L);
        ce_rand = 1'b0;
        cycles(2);
        lb = 1'b0;
        chk("lb_no_overrun", 32'(ovr_cnt - base), 32'd0);
        drain();
    endtask

    initial begin
        int t, base;
        logic [7:0] b;
        bit pbit, sbit;
        rst = 1'b1; tx_wr = 1'b0; rx_rd = 1'b0; tx_data = 8'h00; baud_div = 16'd0;
        pe = 1'b0; oe = 1'b0; stop = 1'b0; rxd_drv = 1'b1; lb = 1'b0;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_tx_full", 32'(tx_full), 32'd0);
        chk("rst_tx_idle", 32'(tx_idle), 32'd1);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_perr", 32'(rx_perr), 32'd0);
        chk("rst_rx_ferr", 32'(rx_ferr), 32'd0);
        chk("rst_rx_ovr", 32'(rx_ovr), 32'd0);

        tx_stream(1'b1, 0);
        repeat (5) tx_stream(1'b0, $urandom_range(0, 5));

        loopback(1'b1, 3);
        repeat (2) loopback(1'b0, 4);

        // Framing error followed by a held-low break, then a clean frame
        baud_div = 16'($urandom_range(0, 2));
        pe = 1'b0; oe = 1'b0; stop = 1'b0;
        L = 16 * (int'(baud_div) + 1);
        rx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3 * L);
        mpush(8'h3C, 1'b0, 1'b1);
        b = 8'($urandom);
        rx_frame(b, 1'b0, 1'b0, 1'b1, 0);
        mpush(b, 1'b0, 1'b0);
        drain();

        pe = 1'b1; oe = 1'b0;
        rx_frame(8'h01, 1'b1, 1'b0, 1'b1, 0);
        mpush(8'h01, 1'b1, 1'b0);
        drain();
        rx_frame(8'h01, 1'b1, 1'b1, 1'b1, 0);
        mpush(8'h01, 1'b0, 1'b0);
        drain();
        repeat (6) begin
            oe = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            pbit = 1'($urandom_range(0, 1));
            sbit = ($urandom_range(0, 3) != 0);
            rx_frame(b, 1'b1, pbit, sbit, 0);
            mpush(b, pbit != ((^b) ^ oe), !sbit);
            drain();
        end

        // Five frames into a four-deep FIFO with no reads
        pe = 1'b0;
        m_ovr = 0;
        base = ovr_cnt;
        repeat (5) begin
            b = 8'($urandom);
            rx_frame(b, 1'b0, 1'b0, 1'b1, 0);
            mpush(b, 1'b0, 1'b0);
        end
        chk("ovr_pulses", 32'(ovr_cnt - base), 32'(m_ovr));
        drain();

        // Short low glitch is a false start
        rxd_drv = 1'b0;
        cycles(4 * (int'(baud_div) + 1));
        rxd_drv = 1'b1;
        cycles(3 * L);
        chk("glitch_rx_empty", 32'(rx_empty), 32'd1);

        // Reset in the middle of a transmit frame with RX data pending
        baud_div = 16'd0; pe = 1'b0; stop = 1'b0; L = 16;
        rx_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);
        chk("pre_rst_rx_nonempty", 32'(rx_empty), 32'd0);
        tx_data = 8'($urandom);
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        t = 0;
        while (txd !== 1'b0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        cycles(5);
        chk("pre_rst_txd_low", 32'(txd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_tx_idle", 32'(tx_idle), 32'd1);
        chk("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        mq.delete();
        cycles(2 * L);
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_tx_idle", 32'(tx_idle), 32'd1);
        chk("post_rst_rx_empty", 32'(rx_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
